// File: rtl/multicycle_sequencer_if.sv
// Memory handshake bundle for multicycle_sequencer: instruction-fetch and data-memory
// request/acknowledge pairs. The sequencer takes the master side. A memory model
// or arbiter takes the slave side.
interface multicycle_sequencer_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ready,
    output dmem_ready
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control FSM.
// Each instruction steps through FETCH, DECODE, EXEC, MEM and WB.
// The FSM issues handshaked imem/dmem requests and gates register-file writes and PC updates.
// It halts on ECALL/EBREAK, on an illegal opcode, or on a memory-wait timeout.
// Optional feature macro: SEQ_PERF_CNT_EN adds the cycle_cnt and instret_cnt counters.
module multicycle_sequencer #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned WAIT_W   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          run,
  input  logic [6:0]                    ir_opcode,
  input  logic                          branch_taken,
  multicycle_sequencer_if.master        mem_if,
  output logic                          ir_load,
  output logic                          reg_write_en,
  output logic                          pc_write,
  output logic                          pc_src,
  output logic                          halted,
  output logic [1:0]                    err_code
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]                   cycle_cnt,
  output logic [31:0]                   instret_cnt
`endif
);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  typedef enum logic [2:0] {
    ClsAlu,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJump
  } cls_e;

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrEnv     = 2'b01;
  localparam logic [1:0] ErrIllegal = 2'b10;
  localparam logic [1:0] ErrTimeout = 2'b11;

  localparam logic [WAIT_W-1:0] MaxWait = WAIT_W'(MAX_WAIT);

  state_e            state_q, state_d;
  cls_e              cls_q, cls_d;
  logic [1:0]        err_q, err_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  // Set once a fetch request has been raised, so that it holds even if run drops.
  logic              pend_q, pend_d;
  logic              imem_req;

  // State, class, error, wait counter and pending-fetch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      cls_q   <= ClsAlu;
      err_q   <= ErrNone;
      wait_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
      pend_q  <= pend_d;
    end
  end

  // Next-state logic plus state-decoded strobes. ir_load alone follows imem_ready combinationally.
  always_comb begin
    state_d       = state_q;
    cls_d         = cls_q;
    err_d         = err_q;
    wait_d        = wait_q;
    pend_d        = 1'b0;
    // rst_n is gated in so that every output reads 0 while reset is held, even with run high.
    imem_req      = 1'b0;
    ir_load       = 1'b0;
    mem_if.dmem_req = 1'b0;
    mem_if.dmem_we  = 1'b0;
    reg_write_en  = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;

    unique case (state_q)
      StFetch: begin
        imem_req = rst_n & (run | pend_q);
        ir_load  = imem_req & mem_if.imem_ready;
        if (imem_req) begin
          if (mem_if.imem_ready) begin
            state_d = StDecode;
          end else if (wait_q == MaxWait) begin
            state_d = StHalt;
            err_d   = ErrTimeout;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
            pend_d = 1'b1;
          end
        end
      end

      StDecode: begin
        state_d = StExec;
        case (ir_opcode)
          7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: cls_d = ClsAlu;
          7'b0000011:                                     cls_d = ClsLoad;
          7'b0100011:                                     cls_d = ClsStore;
          7'b1100011:                                     cls_d = ClsBranch;
          7'b1101111, 7'b1100111:                         cls_d = ClsJump;
          7'b1110011: begin
            state_d = StHalt;
            err_d   = ErrEnv;
          end
          default: begin
            state_d = StHalt;
            err_d   = ErrIllegal;
          end
        endcase
      end

      StExec: begin
        unique case (cls_q)
          ClsLoad, ClsStore: begin
            state_d = StMem;
            wait_d  = '0;
          end
          ClsBranch: begin
            pc_write = 1'b1;
            pc_src   = branch_taken;
            state_d  = StFetch;
            wait_d   = '0;
          end
          default: state_d = StWb;
        endcase
      end

      StMem: begin
        mem_if.dmem_req = 1'b1;
        mem_if.dmem_we  = (cls_q == ClsStore);
        if (mem_if.dmem_ready) begin
          if (cls_q == ClsStore) begin
            pc_write = 1'b1;
            state_d  = StFetch;
            wait_d   = '0;
          end else begin
            state_d = StWb;
          end
        end else if (wait_q == MaxWait) begin
          state_d = StHalt;
          err_d   = ErrTimeout;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      StWb: begin
        reg_write_en = 1'b1;
        pc_write     = 1'b1;
        pc_src       = (cls_q == ClsJump);
        state_d      = StFetch;
        wait_d       = '0;
      end

      StHalt: begin
        state_d = StHalt;
      end

      default: begin
        state_d = StFetch;
        wait_d  = '0;
      end
    endcase
  end

  assign mem_if.imem_req = imem_req;
  assign halted          = (state_q == StHalt);
  assign err_code        = err_q;

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instret_cnt_q, instret_cnt_d;

  // Performance counters; both wrap naturally at 2^32.
  always_comb begin
    cycle_cnt_d   = cycle_cnt_q + (halted ? 32'd0 : 32'd1);
    instret_cnt_d = instret_cnt_q + (pc_write ? 32'd1 : 32'd0);
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
    end else begin
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
    end
  end

  assign cycle_cnt   = cycle_cnt_q;
  assign instret_cnt = instret_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer.
// Each cycle packs the outputs into one vector and compares it with a hand-derived constant.
module tb_multicycle_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic [6:0] ir_opcode;
  logic       branch_taken;
  logic       ir_load;
  logic       reg_write_en;
  logic       pc_write;
  logic       pc_src;
  logic       halted;
  logic [1:0] err_code;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instret_cnt;
`endif

  int checks;
  int failures;

  multicycle_sequencer_if bus ();

  multicycle_sequencer #(
    .MAX_WAIT (15),
    .WAIT_W   (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .ir_opcode    (ir_opcode),
    .branch_taken (branch_taken),
    .mem_if       (bus.master),
    .ir_load      (ir_load),
    .reg_write_en (reg_write_en),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .halted       (halted),
    .err_code     (err_code)
`ifdef SEQ_PERF_CNT_EN
    ,
    .cycle_cnt    (cycle_cnt),
    .instret_cnt  (instret_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Vector layout: {imem_req, ir_load, dmem_req, dmem_we, reg_write_en, pc_write, pc_src,
  //                 halted, err_code[1:0]}
  localparam logic [9:0] VIdle   = 10'b0000000000;
  localparam logic [9:0] VFetch  = 10'b1100000000;
  localparam logic [9:0] VFreq   = 10'b1000000000;
  localparam logic [9:0] VMemRd  = 10'b0010000000;
  localparam logic [9:0] VMemSt  = 10'b0011010000;
  localparam logic [9:0] VWb     = 10'b0000110000;
  localparam logic [9:0] VWbJ    = 10'b0000111000;
  localparam logic [9:0] VBrT    = 10'b0000011000;
  localparam logic [9:0] VBrN    = 10'b0000010000;
  localparam logic [9:0] VHIll   = 10'b0000000110;
  localparam logic [9:0] VHEnv   = 10'b0000000101;
  localparam logic [9:0] VHTo    = 10'b0000000111;

  localparam logic [6:0] OpAdd   = 7'b0110011;
  localparam logic [6:0] OpLw    = 7'b0000011;
  localparam logic [6:0] OpSw    = 7'b0100011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpSys   = 7'b1110011;

  function automatic logic [9:0] outs();
    return {bus.imem_req, ir_load, bus.dmem_req, bus.dmem_we, reg_write_en, pc_write, pc_src,
            halted, err_code};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Inputs for the current cycle are already set; check mid-cycle, then advance one cycle.
  task automatic expect_cycle(input string tag, input logic [9:0] exp);
    #1;
    check_eq(tag, 32'(outs()), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  // Hold reset with run and ready high, check that all outputs are 0, then release.
  task automatic start(input logic [6:0] op);
    rst_n          = 1'b0;
    run            = 1'b1;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    ir_opcode      = op;
    branch_taken   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_outs", 32'(outs()), 32'(VIdle));
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;

    // ADD with zero-wait memory: write-back in cycle 4.
    start(OpAdd);
    expect_cycle("add_c1", VFetch);
    expect_cycle("add_c2", VIdle);
    expect_cycle("add_c3", VIdle);
    run = 1'b0;
    expect_cycle("add_c4", VWb);
    expect_cycle("add_c5", VIdle);

    // LW with dmem_ready arriving on the 4th MEM cycle.
    start(OpLw);
    bus.dmem_ready = 1'b0;
    expect_cycle("lw_c1", VFetch);
    run = 1'b0;
    expect_cycle("lw_c2", VIdle);
    expect_cycle("lw_c3", VIdle);
    for (int i = 0; i < 4; i++) begin
      bus.dmem_ready = (i == 3);
      expect_cycle($sformatf("lw_mem%0d", i), VMemRd);
    end
    bus.dmem_ready = 1'b0;
    expect_cycle("lw_wb", VWb);
    expect_cycle("lw_after", VIdle);

    // SW with immediate ack: PC update in MEM, no register write.
    start(OpSw);
    expect_cycle("sw_c1", VFetch);
    run = 1'b0;
    expect_cycle("sw_c2", VIdle);
    expect_cycle("sw_c3", VIdle);
    expect_cycle("sw_c4", VMemSt);
    expect_cycle("sw_c5", VIdle);

    // BEQ taken, then BEQ not taken.
    start(OpBeq);
    branch_taken = 1'b1;
    expect_cycle("beqt_c1", VFetch);
    expect_cycle("beqt_c2", VIdle);
    expect_cycle("beqt_c3", VBrT);
    branch_taken = 1'b0;
    expect_cycle("beqn_c1", VFetch);
    expect_cycle("beqn_c2", VIdle);
    run = 1'b0;
    expect_cycle("beqn_c3", VBrN);
    expect_cycle("beqn_c4", VIdle);

    // JAL: write-back with pc_src=1.
    start(OpJal);
    expect_cycle("jal_c1", VFetch);
    run = 1'b0;
    expect_cycle("jal_c2", VIdle);
    expect_cycle("jal_c3", VIdle);
    expect_cycle("jal_c4", VWbJ);

    // Illegal opcode: HALT with err 10, held despite run/ready.
    start(7'b0000000);
    expect_cycle("ill_c1", VFetch);
    expect_cycle("ill_c2", VIdle);
    for (int i = 0; i < 4; i++) expect_cycle($sformatf("ill_hold%0d", i), VHIll);

    // ECALL/EBREAK: HALT with err 01.
    start(OpSys);
    expect_cycle("sys_c1", VFetch);
    expect_cycle("sys_c2", VIdle);
    expect_cycle("sys_c3", VHEnv);

    // Fetch timeout: request raised, then run drops; the request holds.
    // The counter counts 0..15, and the 16th request cycle halts.
    start(OpAdd);
    bus.imem_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (i == 3) run = 1'b0;
      expect_cycle($sformatf("to_c%0d", i), VFreq);
    end
    expect_cycle("to_halt", VHTo);
    expect_cycle("to_hold", VHTo);

    // Idle FETCH with run=0 does not count. Then ready arrives when the count sits at MAX_WAIT.
    start(OpAdd);
    run            = 1'b0;
    bus.imem_ready = 1'b0;
    for (int i = 0; i < 20; i++) expect_cycle($sformatf("idle_c%0d", i), VIdle);
    run = 1'b1;
    for (int i = 1; i <= 15; i++) expect_cycle($sformatf("rw_c%0d", i), VFreq);
    bus.imem_ready = 1'b1;
    expect_cycle("rw_ready", VFetch);
    run = 1'b0;
    expect_cycle("rw_dec", VIdle);
    expect_cycle("rw_exec", VIdle);
    expect_cycle("rw_wb", VWb);

    // Reset asserted during MEM: dmem_req drops at once; the FSM restarts in FETCH.
    start(OpLw);
    bus.dmem_ready = 1'b0;
    expect_cycle("rst_c1", VFetch);
    run = 1'b0;
    expect_cycle("rst_c2", VIdle);
    expect_cycle("rst_c3", VIdle);
    #1;
    check_eq("rst_mem_req", 32'(outs()), 32'(VMemRd));
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_drop", 32'(outs()), 32'(VIdle));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expect_cycle("rst_rel_idle", VIdle);
    run            = 1'b1;
    bus.imem_ready = 1'b1;
    ir_opcode      = OpAdd;
    expect_cycle("rst_rel_fetch", VFetch);
    run = 1'b0;
    expect_cycle("rst_rel_dec", VIdle);
    expect_cycle("rst_rel_exec", VIdle);
    expect_cycle("rst_rel_wb", VWb);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
